// File: rtl/hex_inv_pkg.sv
// Shared types, sizes and the stimulus pattern table for the hex-inverter self-test.
// HEX_INV_BIST_WALK_EN appends six walking-one patterns and widens the pattern index.
package hex_inv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int GATES    = 6;
  localparam int NUM_BASE = 4;
  localparam int NUM_WALK = 6;

`ifdef HEX_INV_BIST_WALK_EN
  localparam int NUM_PAT = NUM_BASE + NUM_WALK;
`else
  localparam int NUM_PAT = NUM_BASE;
`endif

  localparam int IDX_W = $clog2(NUM_PAT);

  // Stimulus for pattern slot idx; the expected gate response is its complement.
  function automatic logic [GATES-1:0] pattern_at(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): return 6'h00;
      IDX_W'(1): return 6'h3F;
      IDX_W'(2): return 6'h15;
      IDX_W'(3): return 6'h2A;
`ifdef HEX_INV_BIST_WALK_EN
      IDX_W'(4): return 6'h01;
      IDX_W'(5): return 6'h02;
      IDX_W'(6): return 6'h04;
      IDX_W'(7): return 6'h08;
      IDX_W'(8): return 6'h10;
      IDX_W'(9): return 6'h20;
`endif
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/hex_inv_bist_settle_timer.sv
// Loadable down-counter with a zero flag that times the settle window of each pattern.
// Zero latency on the flag; holds at zero, load has priority over decrement.
// No flow control: the FSM owns load/dec strobes.
module bist_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hex_inv_bist.sv
// Built-in self-test for a hex inverter; optional walking-one patterns under HEX_INV_BIST_WALK_EN.
// Latency: run starts the cycle after start, busy for NUM_PAT*(SETTLE_CYCLES+2) cycles, then a done pulse.
// No backpressure: start is only sampled in IDLE, abort cancels a run at any busy cycle.
module hex_inv_bist
  import hex_inv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [GATES-1:0] drive_a,
  input  logic [GATES-1:0] sense_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [GATES-1:0] fail_mask
);

  // The timer is loaded with one less than the window so SETTLE lasts exactly SETTLE_CYCLES.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [GATES-1:0] mask_q;
  logic             pass_q;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic             last_pat;
  logic [GATES-1:0] cur_pat;
  logic [GATES-1:0] mask_next;

  assign last_pat  = (idx_q == IDX_W'(NUM_PAT - 1));
  assign cur_pat   = pattern_at(idx_q);
  assign mask_next = mask_q | (sense_y ^ ~cur_pat);

  bist_settle_timer #(.W(4)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    drive_a  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = DRIVE;
      end
      DRIVE: begin
        busy     = 1'b1;
        drive_a  = cur_pat;
        tmr_load = 1'b1;
        if (abort)                   state_d = IDLE;
        else if (SETTLE_CYCLES == 0) state_d = CHECK;
        else                         state_d = SETTLE;
      end
      SETTLE: begin
        busy    = 1'b1;
        drive_a = cur_pat;
        if (abort)         state_d = IDLE;
        else if (tmr_zero) state_d = CHECK;
        else               tmr_dec = 1'b1;
      end
      CHECK: begin
        busy    = 1'b1;
        drive_a = cur_pat;
        if (abort)         state_d = IDLE;
        else if (last_pat) state_d = DONE;
        else               state_d = DRIVE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass is resolved on the final CHECK edge so it is already valid during the DONE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      mask_q <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            idx_q  <= '0;
            mask_q <= '0;
            pass_q <= 1'b0;
          end
        end
        DRIVE, SETTLE: begin
          if (abort) pass_q <= 1'b0;
        end
        CHECK: begin
          if (abort) begin
            pass_q <= 1'b0;
          end else begin
            mask_q <= mask_next;
            if (last_pat) pass_q <= (mask_next == '0);
            else          idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pass      = pass_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_hex_inv_bist.sv
// Directed bench for hex_inv_bist: two instances (settle 2 and settle 0) driving a faultable inverter model.
module tb_hex_inv_bist;

`ifdef HEX_INV_BIST_WALK_EN
  localparam int NPAT = 10;
`else
  localparam int NPAT = 4;
`endif

  typedef struct {
    logic       pass;
    logic [5:0] mask;
    int         cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [2];
  logic       abort     [2];
  logic [5:0] drive_a   [2];
  logic [5:0] sense_y   [2];
  logic       busy      [2];
  logic       done      [2];
  logic       pass      [2];
  logic [5:0] fail_mask [2];
  logic [5:0] st1       [2];
  logic [5:0] st0       [2];
  logic [5:0] noise     [2];
  logic       glitch    [2];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Inverter model with stuck-at faults; glitch replaces the outputs with noise outside CHECK.
  assign sense_y[0] = glitch[0] ? noise[0] : ((~drive_a[0] | st1[0]) & ~st0[0]);
  assign sense_y[1] = glitch[1] ? noise[1] : ((~drive_a[1] | st1[1]) & ~st0[1]);

  hex_inv_bist #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .drive_a(drive_a[0]), .sense_y(sense_y[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .fail_mask(fail_mask[0])
  );

  hex_inv_bist #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .drive_a(drive_a[1]), .sense_y(sense_y[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .fail_mask(fail_mask[1])
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [5:0] tb_pat(input int i);
    case (i)
      0: return 6'h00;  1: return 6'h3F;  2: return 6'h15;  3: return 6'h2A;
      4: return 6'h01;  5: return 6'h02;  6: return 6'h04;  7: return 6'h08;
      8: return 6'h10;  9: return 6'h20;
      default: return 6'h00;
    endcase
  endfunction

  // Accumulated mismatch over the first np patterns for the given fault set.
  function automatic logic [5:0] model_mask(input int np, input logic [5:0] s1, input logic [5:0] s0);
    logic [5:0] m = '0;
    for (int p = 0; p < np; p++) begin
      logic [5:0] good = ~tb_pat(p);
      m |= (((good | s1) & ~s0) ^ good);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int d, input bit hold);
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    if (!hold) start[d] = 1'b0;
  endtask

  // Full run: pushes the expected result, tracks drive_a per busy cycle, pops on done.
  task automatic do_run(input int d, input logic [5:0] s1, input logic [5:0] s0,
                        input bit glitchy, input bit hold);
    int         s   = settle_of(d);
    int         cyc = 0;
    int         bad = 0;
    bit         ended = 0;
    exp_t       e;
    exp_t       got;
    logic [5:0] exp_drv[$];
    st1[d]   = s1;
    st0[d]   = s0;
    e.mask   = model_mask(NPAT, s1, s0);
    e.pass   = (e.mask == 6'h00);
    e.cycles = NPAT * (s + 2);
    sb.push_back(e);
    for (int p = 0; p < NPAT; p++)
      for (int k = 0; k < s + 2; k++) exp_drv.push_back(tb_pat(p));
    pulse_start(d, hold);
    for (int t = 0; t < 200 && !ended; t++) begin
      if (busy[d]) begin
        if (cyc >= exp_drv.size() || drive_a[d] !== exp_drv[cyc]) bad++;
        glitch[d] = glitchy && ((cyc % (s + 2)) != s + 1);
        noise[d]  = 6'($urandom);
        cyc++;
        @(negedge clk);
      end else begin
        ended = 1;
      end
    end
    glitch[d] = 1'b0;
    got = sb.pop_front();
    check("run_ended",   32'(busy[d]), 32'd0);
    check("done_pulse",  32'(done[d]), 32'd1);
    check("busy_cycles", 32'(cyc), 32'(got.cycles));
    check("drive_seq",   32'(bad), 32'd0);
    check("pass",        32'(pass[d]), 32'(got.pass));
    check("fail_mask",   32'(fail_mask[d]), 32'(got.mask));
    check("drive_done",  32'(drive_a[d]), 32'd0);
    @(negedge clk);
    if (hold) begin
      check("no_restart", 32'(busy[d]), 32'd0);
      start[d] = 1'b0;
    end
    check("done_one_cyc", 32'(done[d]), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_busy",  32'(busy[d]), 32'd0);
    check("hold_pass",  32'(pass[d]), 32'(got.pass));
    check("hold_mask",  32'(fail_mask[d]), 32'(got.mask));
    st1[d] = '0;
    st0[d] = '0;
  endtask

  // Starts a run and cancels it on busy cycle 'at' (0-based) with abort or reset.
  task automatic do_cancel(input int d, input logic [5:0] s1, input logic [5:0] s0,
                           input int at, input bit use_rst);
    int         s = settle_of(d);
    int         cyc = 0;
    int         np = 0;
    logic [5:0] exp_mask;
    st1[d] = s1;
    st0[d] = s0;
    for (int p = 0; p < NPAT; p++) if (p * (s + 2) + s + 1 < at) np++;
    exp_mask = use_rst ? 6'h00 : model_mask(np, s1, s0);
    pulse_start(d, 0);
    for (int t = 0; t < 200 && cyc < at && busy[d]; t++) begin
      cyc++;
      @(negedge clk);
    end
    check("cancel_reach", 32'(cyc), 32'(at));
    if (use_rst) rst = 1'b1;
    else         abort[d] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    abort[d] = 1'b0;
    check("cancel_busy",  32'(busy[d]), 32'd0);
    check("cancel_done",  32'(done[d]), 32'd0);
    check("cancel_drive", 32'(drive_a[d]), 32'd0);
    check("cancel_pass",  32'(pass[d]), 32'd0);
    check("cancel_mask",  32'(fail_mask[d]), 32'(exp_mask));
    repeat (3) @(negedge clk);
    check("cancel_nodone", 32'(done[d]), 32'd0);
    check("cancel_idle",   32'(busy[d]), 32'd0);
    st1[d] = '0;
    st0[d] = '0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; st1[d] = '0; st0[d] = '0;
      noise[d] = '0;   glitch[d] = 1'b0;
    end
    start[0] = 1'b1;
    abort[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    rst = 1'b0;
    check("rst_busy",  32'(busy[0]), 32'd0);
    check("rst_done",  32'(done[0]), 32'd0);
    check("rst_pass",  32'(pass[0]), 32'd0);
    check("rst_mask",  32'(fail_mask[0]), 32'd0);
    check("rst_drive", 32'(drive_a[0]), 32'd0);

    // Healthy part, outputs corrupted outside CHECK
    do_run(0, 6'h00, 6'h00, 1, 0);

    // abort alone in IDLE, then abort together with start
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    check("idle_abort_busy", 32'(busy[0]), 32'd0);
    check("idle_abort_pass", 32'(pass[0]), 32'd1);
    start[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("abort_start_busy", 32'(busy[0]), 32'd0);
    check("abort_start_pass", 32'(pass[0]), 32'd1);

    // Gate 3 stuck high, gate 6 stuck low
    do_run(0, 6'h04, 6'h00, 1, 0);
    do_run(0, 6'h00, 6'h20, 0, 0);
    do_run(0, 6'h00, 6'h00, 0, 0);

    // Abort on busy cycle 7 and later with a captured fault; reset on busy cycle 5
    do_cancel(0, 6'h00, 6'h00, 6, 0);
    do_cancel(0, 6'h04, 6'h00, 10, 0);
    do_cancel(0, 6'h00, 6'h01, 4, 1);
    do_run(0, 6'h00, 6'h00, 1, 0);

    // Zero settle window, start held across the whole run
    do_run(1, 6'h00, 6'h00, 1, 1);
    do_run(1, 6'h21, 6'h00, 1, 0);
    do_cancel(1, 6'h00, 6'h02, 3, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
